// File: rtl/hamming_enc_arbiter.sv
// Round-robin arbiter feeding one shared SECDED(16,11) encoder; accept-to-out_valid latency is 1 cycle.
// Output register holds while out_ready=0 (no request accepted) and reloads on the same edge it drains.
module hamming_enc_arbiter #(
   parameter int SEQ_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic [10:0]      req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [10:0]      req1_data,
   output logic             req1_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_cw,
   output logic             out_src,
   output logic [SEQ_W-1:0] out_seq
);

   typedef struct packed {
      logic [15:0]      cw;
      logic             src;
      logic [SEQ_W-1:0] seq;
   } out_t;

   // Data-bit coverage of each Hamming parity bit, d[10] on the left.
   localparam logic [10:0] P1_MASK = 11'h55B;
   localparam logic [10:0] P2_MASK = 11'h66D;
   localparam logic [10:0] P3_MASK = 11'h78E;
   localparam logic [10:0] P4_MASK = 11'h7F0;

   function automatic logic [15:0] encode(input logic [10:0] d);
      logic p0, p1, p2, p3, p4;
      p1 = ^(d & P1_MASK);
      p2 = ^(d & P2_MASK);
      p3 = ^(d & P3_MASK);
      p4 = ^(d & P4_MASK);
      p0 = ^{d, p4, p3, p2, p1};
      return {d, p4, p3, p2, p1, p0};
   endfunction

   out_t             out_q;
   logic             out_valid_q;
   logic [SEQ_W-1:0] seq_cnt;
   logic             rr_last;

   logic             can_load;
   logic             grant0;
   logic             grant1;
   logic             accept;
   logic [10:0]      sel_data;

   // rr_last=1 means ch1 was served last, so ch0 wins a tie.
   always_comb begin
      can_load = !out_valid_q | out_ready;
      grant0   = req0_valid & (!req1_valid | rr_last);
      grant1   = req1_valid & (!req0_valid | !rr_last);
      sel_data = grant1 ? req1_data : req0_data;
   end

   assign req0_ready = !rst & can_load & grant0;
   assign req1_ready = !rst & can_load & grant1;
   assign accept     = req0_ready | req1_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
         seq_cnt     <= '0;
         rr_last     <= 1'b1;
      end else if (accept) begin
         out_q.cw    <= encode(sel_data);
         out_q.src   <= grant1;
         out_q.seq   <= seq_cnt;
         out_valid_q <= 1'b1;
         seq_cnt     <= seq_cnt + 1'b1;
         rr_last     <= grant1;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign out_cw    = out_q.cw;
   assign out_src   = out_q.src;
   assign out_seq   = out_q.seq;

endmodule
